param_mux_scanner: RTL and testbench

//  Parametrised, registered N-channel data multiplexer with manual and auto-scan modes.
//  In manual mode, it routes the channel chosen by an external select to a registered output.
//  In scan mode, it steps through the channels on its own, holding each one for a programmable dwell time.

---
 rtl/param_mux_scanner.sv | 115 +++++++++++
 tb/tb_param_mux_scanner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_mux_scanner.sv
// Registered N-channel data mux with manual select and auto-scan stepping.
// Optional feature: define SCAN_MASK_EN to add the ch_mask port and skip disabled channels in scan.
module param_mux_scanner #(
  parameter int CH_N    = 4,
  parameter int DW      = 1,
  parameter int SEL_W   = $clog2(CH_N),
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH_N*DW-1:0]   din,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 hold,
`ifdef SCAN_MASK_EN
  input  logic [CH_N-1:0]      ch_mask,
`endif
  output logic [DW-1:0]        dout,
  output logic [SEL_W-1:0]     ch_out,
  output logic                 ch_chg,
  output logic                 wrap
);

  localparam int CH_PAD = 1 << SEL_W;

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t             state;
  logic [SEL_W-1:0]   ch_cur;
  logic [DWELL_W-1:0] cnt;
  logic [DW-1:0]      dout_p1;
  logic               ch_chg_p1;
  logic               wrap_p1;

  logic [DW-1:0]      ch_data_p0 [CH_PAD];
  logic [CH_N-1:0]    scan_mask;
  logic               sel_ok;
  logic               adv_ok;
  logic [SEL_W-1:0]   adv_ch;
  logic [SEL_W-1:0]   cand;

`ifdef SCAN_MASK_EN
  assign scan_mask = ch_mask;
`else
  assign scan_mask = '1;
`endif

  // Unpack channels; padding entries cover index codes above CH_N-1.
  always_comb begin
    for (int i = 0; i < CH_PAD; i++) ch_data_p0[i] = '0;
    for (int i = 0; i < CH_N; i++)   ch_data_p0[i] = din[i*DW +: DW];
  end

  assign sel_ok = (32'(sel) < 32'(CH_N));

  // Nearest enabled channel after ch_cur, searching cyclically; lands on
  // ch_cur itself only when it is the sole enabled channel.
  always_comb begin
    adv_ok = 1'b0;
    adv_ch = ch_cur;
    cand   = ch_cur;
    for (int k = CH_N; k >= 1; k--) begin
      cand = SEL_W'((32'(ch_cur) + 32'(k)) % 32'(CH_N));
      if (scan_mask[cand]) begin
        adv_ok = 1'b1;
        adv_ch = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MANUAL;
      ch_cur    <= '0;
      cnt       <= '0;
      dout_p1   <= '0;
      ch_chg_p1 <= 1'b0;
      wrap_p1   <= 1'b0;
    end else if (hold) begin
      ch_chg_p1 <= 1'b0;
      wrap_p1   <= 1'b0;
    end else begin
      // Stage p0 -> p1: data sampled with the channel in force before this edge.
      dout_p1   <= ch_data_p0[ch_cur];
      state     <= mode ? SCAN : MANUAL;
      ch_chg_p1 <= 1'b0;
      wrap_p1   <= 1'b0;
      if (!mode) begin
        cnt <= '0;
        if (sel_ok && (sel != ch_cur)) begin
          ch_cur    <= sel;
          ch_chg_p1 <= 1'b1;
        end
      end else if (state == MANUAL) begin
        cnt <= '0;
      end else if (cnt == dwell) begin
        cnt <= '0;
        if (adv_ok) begin
          ch_cur    <= adv_ch;
          ch_chg_p1 <= (adv_ch != ch_cur);
          wrap_p1   <= (adv_ch <= ch_cur);
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dout   = dout_p1;
  assign ch_out = ch_cur;
  assign ch_chg = ch_chg_p1;
  assign wrap   = wrap_p1;

endmodule

// File: tb/tb_param_mux_scanner.sv
// Bench for param_mux_scanner: vector table, directed scan/hold/reset sequences, random vs model.
module tb_param_mux_scanner;

  localparam int CH_N = 4, DW = 1, SEL_W = 2, DWELL_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH_N*DW-1:0]   din;
  logic [SEL_W-1:0]     sel;
  logic                 mode;
  logic [DWELL_W-1:0]   dwell;
  logic                 hold;
  logic [CH_N-1:0]      tb_mask;
  logic [DW-1:0]        dout;
  logic [SEL_W-1:0]     ch_out;
  logic                 ch_chg;
  logic                 wrap;

  // Second instance: 8 channels of 4-bit data
  logic [31:0] din8;
  logic [2:0]  sel8;
  logic        mode8;
  logic [7:0]  dwell8;
  logic        hold8;
  logic [7:0]  mask8;
  logic [3:0]  dout8;
  logic [2:0]  ch8;
  logic        chg8;
  logic        wrap8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_mux_scanner #(.CH_N(CH_N), .DW(DW), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) u_dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .dwell(dwell), .hold(hold),
`ifdef SCAN_MASK_EN
    .ch_mask(tb_mask),
`endif
    .dout(dout), .ch_out(ch_out), .ch_chg(ch_chg), .wrap(wrap)
  );

  param_mux_scanner #(.CH_N(8), .DW(4), .SEL_W(3), .DWELL_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .din(din8), .sel(sel8), .mode(mode8), .dwell(dwell8), .hold(hold8),
`ifdef SCAN_MASK_EN
    .ch_mask(mask8),
`endif
    .dout(dout8), .ch_out(ch8), .ch_chg(chg8), .wrap(wrap8)
  );

  // Reference model state for the 4-channel instance
  bit          m_scan;
  int          m_ch, m_cnt;
  logic [DW-1:0] m_dout;
  bit          m_chg, m_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_ch = 0; m_cnt = 0; m_dout = '0; m_chg = 0; m_wrap = 0;
  endtask

  // One clock edge of the behaviour, evaluated on the inputs present before the edge.
  task automatic model_edge();
    int nx;
    if (hold) begin
      m_chg = 0; m_wrap = 0;
      return;
    end
    m_dout = din[m_ch*DW +: DW];
    m_chg = 0; m_wrap = 0;
    if (!mode) begin
      m_cnt = 0;
      if (int'(sel) < CH_N && int'(sel) != m_ch) begin
        m_ch = int'(sel); m_chg = 1;
      end
    end else if (!m_scan) begin
      m_cnt = 0;
    end else if (m_cnt == int'(dwell)) begin
      m_cnt = 0;
      nx = -1;
      for (int k = 1; k <= CH_N; k++)
        if (nx < 0 && tb_mask[(m_ch + k) % CH_N]) nx = (m_ch + k) % CH_N;
      if (nx >= 0) begin
        m_wrap = (nx <= m_ch);
        m_chg  = (nx != m_ch);
        m_ch   = nx;
      end
    end else begin
      m_cnt = (m_cnt + 1) % (1 << DWELL_W);
    end
    m_scan = mode;
  endtask

  task automatic compare_all(input string name);
    chk({name, ".dout"},   32'(dout),   32'(m_dout));
    chk({name, ".ch_out"}, 32'(ch_out), 32'(m_ch));
    chk({name, ".ch_chg"}, 32'(ch_chg), 32'(m_chg));
    chk({name, ".wrap"},   32'(wrap),   32'(m_wrap));
  endtask

  task automatic tick(input string name);
    model_edge();
    @(posedge clk); #1;
    compare_all(name);
  endtask

  typedef struct {
    logic [3:0] din;
    logic [1:0] sel;
    logic [1:0] ech;
    logic       edout;
    logic       echg;
  } vec_t;

  vec_t tbl[7];
  int   exp3[13];
  int   exp4[8];
  logic [3:0] nib;

  initial begin
    tbl[0] = '{4'b1010, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{4'b1010, 2'd1, 2'd1, 1'b0, 1'b1};
    tbl[2] = '{4'b1010, 2'd2, 2'd2, 1'b1, 1'b1};
    tbl[3] = '{4'b1010, 2'd3, 2'd3, 1'b0, 1'b1};
    tbl[4] = '{4'b1010, 2'd1, 2'd1, 1'b1, 1'b1};
    tbl[5] = '{4'b1010, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[6] = '{4'b1010, 2'd1, 2'd1, 1'b1, 1'b0};
    exp3 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    exp4 = '{1, 2, 3, 0, 0, 0, 0, 1};

    rst = 1'b1; din = '0; sel = '0; mode = 1'b0; dwell = '0; hold = 1'b0; tb_mask = '1;
    din8 = '0; sel8 = '0; mode8 = 1'b0; dwell8 = '0; hold8 = 1'b0; mask8 = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.dout", 32'(dout), 0);
    chk("reset.ch_out", 32'(ch_out), 0);
    chk("reset.ch_chg", 32'(ch_chg), 0);
    chk("reset.wrap", 32'(wrap), 0);
    rst = 1'b0;

    // Manual selection table
    for (int i = 0; i < 7; i++) begin
      din = tbl[i].din; sel = tbl[i].sel; mode = 1'b0;
      tick("man");
      chk("man_tbl.ch_out", 32'(ch_out), 32'(tbl[i].ech));
      chk("man_tbl.dout",   32'(dout),   32'(tbl[i].edout));
      chk("man_tbl.ch_chg", 32'(ch_chg), 32'(tbl[i].echg));
      chk("man_tbl.wrap",   32'(wrap),   0);
    end

    // Scan with dwell=2 from channel 0
    sel = 2'd0; tick("pre3");
    mode = 1'b1; dwell = 8'd2;
    for (int i = 0; i < 13; i++) begin
      tick("scan3");
      chk("scan3.ch_out", 32'(ch_out), 32'(exp3[i]));
      chk("scan3.wrap", 32'(wrap), 32'(i == 12));
      chk("scan3.ch_chg", 32'(ch_chg), 32'(i > 0 && exp3[i] != exp3[i-1]));
    end

    // dwell=0 with hold on steps 5..7
    dwell = 8'd0;
    for (int i = 0; i < 8; i++) begin
      hold = (i >= 4 && i <= 6);
      tick("hold4");
      chk("hold4.ch_out", 32'(ch_out), 32'(exp4[i]));
      chk("hold4.ch_chg", 32'(ch_chg), 32'(!(i >= 4 && i <= 6)));
    end
    hold = 1'b0;

    // Scan to channel 2, drop to manual with sel=0, then resume scan
    dwell = 8'd2;
    repeat (3) tick("to2");
    chk("to2.ch_out", 32'(ch_out), 2);
    sel = 2'd0; mode = 1'b0;
    tick("sc2man");
    chk("sc2man.ch_out", 32'(ch_out), 0);
    mode = 1'b1;
    tick("man2sc");
    repeat (2) tick("resume");
    chk("resume.hold_ch", 32'(ch_out), 0);
    tick("resume");
    chk("resume.step_ch", 32'(ch_out), 1);

    // Async reset between edges while scanning
    dwell = 8'd0;
    repeat (2) tick("prerst");
    #3 rst = 1'b1;
    #1;
    chk("arst.dout", 32'(dout), 0);
    chk("arst.ch_out", 32'(ch_out), 0);
    chk("arst.ch_chg", 32'(ch_chg), 0);
    chk("arst.wrap", 32'(wrap), 0);
    model_reset();
    #1 rst = 1'b0;
    tick("postrst");
    chk("postrst.manual_entry", 32'(ch_out), 0);
    tick("postrst2");
    chk("postrst2.ch_out", 32'(ch_out), 1);

`ifdef SCAN_MASK_EN
    mode = 1'b0; sel = 2'd1; tick("mpre");
    mode = 1'b1; dwell = 8'd0; tb_mask = 4'b1010;
    tick("mtrans");
    for (int i = 0; i < 4; i++) begin
      tick("mask");
      chk("mask.ch_out", 32'(ch_out), (i % 2 == 0) ? 3 : 1);
      chk("mask.wrap", 32'(wrap), 32'(i % 2 == 1));
    end
    tb_mask = 4'b0000;
    repeat (2) begin
      tick("mask0");
      chk("mask0.ch_out", 32'(ch_out), 1);
      chk("mask0.pulses", 32'({ch_chg, wrap}), 0);
    end
    tb_mask = 4'b0100;
    tick("mask1a");
    chk("mask1a.ch_out", 32'(ch_out), 2);
    repeat (2) begin
      tick("mask1");
      chk("mask1.pulses", 32'({ch_chg, wrap}), 32'(2'b01));
    end
    tb_mask = '1;
`endif

    // 8 channels x 4 bits: each nibble reaches dout, then a full scan cycle
    din8 = $urandom();
    for (int i = 0; i < 8; i++) begin
      sel8 = 3'(i);
      tick("w8sel");
      chk("w8.ch_out", 32'(ch8), 32'(i));
      tick("w8dat");
      nib = din8[i*4 +: 4];
      chk("w8.dout", 32'(dout8), 32'(nib));
    end
    sel8 = 3'd0; tick("w8rst");
    mode8 = 1'b1; dwell8 = 8'd0;
    tick("w8trans");
    for (int i = 1; i <= 8; i++) begin
      tick("w8scan");
      chk("w8scan.ch_out", 32'(ch8), 32'(i % 8));
      chk("w8scan.wrap", 32'(wrap8), 32'(i == 8));
      chk("w8scan.ch_chg", 32'(chg8), 1);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      din  = 4'($urandom());
      sel  = 2'($urandom());
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 3));
`ifdef SCAN_MASK_EN
      if ($urandom_range(0, 15) == 0) tb_mask = 4'($urandom());
`endif
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
